// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
//   imem_req    : read request valid (fetch -> memory)
//   imem_addr   : word-aligned read address (fetch -> memory)
//   imem_gnt    : request accepted this cycle when imem_req is high (memory -> fetch)
//   imem_rvalid : read data valid, one cycle after the grant, in order (memory -> fetch)
//   imem_rdata  : instruction word (memory -> fetch)
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline. Owns the PC, issues instruction-memory reads,
// buffers returned words in a DEPTH-entry in-order queue and presents the queue head to
// the IF/DEC register. Memory responses are absorbed while stalled; redirects flush the
// queue and discard responses that belong to the abandoned path.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   stall_IF       : hold the head entry this cycle
//   branch_taken   : redirect pulse, branch_target gives the new PC (bits [1:0] ignored)
//   imem           : instruction-memory bus (master side)
//   valid_IF       : instr_IF / pc_plus4_IF carry a real instruction
//   instr_IF       : head instruction, 0 when not valid
//   pc_plus4_IF    : head instruction address + 4, 0 when not valid
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall_IF,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  fetch_stage_if.master imem,
  output logic          valid_IF,
  output logic [31:0]   instr_IF,
  output logic [31:0]   pc_plus4_IF
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } entry_t;

  state_t           state_q, state_n;
  logic [31:0]      pc_q, pc_n;
  logic [CNT_W-1:0] out_q, out_n;
  logic [CNT_W-1:0] drop_q, drop_n;
  logic [CNT_W-1:0] count_q, count_n, cnt_pop;
  logic [PTR_W-1:0] rd_q, rd_n, wr_q, wr_n;
  entry_t           mem_q [DEPTH];
  entry_t           head_n, push_entry;
  logic             head_valid_n;
  logic             req_q, req_n;
  logic             grant, resp, push, pop, flush;
  logic [31:0]      target_aligned;
  logic [31:0]      resp_pc4;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;

  assign target_aligned = branch_target & 32'hFFFF_FFFC;
  assign grant          = req_q && imem.imem_gnt;
  // A response only counts if a request is actually in flight; stale ones after reset are ignored.
  assign resp           = imem.imem_rvalid && (out_q != '0);
  assign pop            = valid_IF && !stall_IF && !branch_taken;

  // Requests since the last redirect are sequential, so the oldest in-flight address
  // sits out_q words behind the PC.
  assign resp_pc4   = pc_q - (32'(out_q) << 2) + 32'd4;
  assign push_entry = '{instr: imem.imem_rdata, pc_plus4: resp_pc4};

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // FSM next-state
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    state_n = RUN;
      RUN:     if (branch_taken && (drop_n != '0)) state_n = DRAIN;
      DRAIN:   if (drop_n == '0) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  // FSM outputs: queue flush and push enables
  always_comb begin
    push  = 1'b0;
    flush = 1'b0;
    case (state_q)
      RUN: begin
        // A response landing in the redirect cycle belongs to the old path and is discarded.
        flush = branch_taken;
        push  = resp && !branch_taken;
      end
      default: ;
    endcase
  end

  // PC, outstanding and drop counters
  always_comb begin
    out_n  = out_q + CNT_W'(grant) - CNT_W'(resp);
    pc_n   = pc_q;
    drop_n = drop_q;
    case (state_q)
      RUN: begin
        if (branch_taken) begin
          // A grant in the redirect cycle is abandoned: it is counted in out_n but pc does not advance.
          pc_n   = target_aligned;
          drop_n = out_n;
        end else if (grant) begin
          pc_n = pc_q + 32'd4;
        end
      end
      DRAIN: begin
        drop_n = drop_q - CNT_W'(resp);
        if (branch_taken) pc_n = target_aligned;
      end
      default: ;
    endcase
  end

  // Queue pointers and next head (head output is registered)
  always_comb begin
    cnt_pop = count_q - CNT_W'(pop);
    if (flush) begin
      count_n = '0;
      rd_n    = '0;
      wr_n    = '0;
    end else begin
      count_n = cnt_pop + CNT_W'(push);
      rd_n    = pop  ? ptr_inc(rd_q) : rd_q;
      wr_n    = push ? ptr_inc(wr_q) : wr_q;
    end
    head_valid_n = (count_n != '0);
    if (!head_valid_n)        head_n = '0;
    else if (cnt_pop == '0)   head_n = push_entry;
    else                      head_n = mem_q[rd_n];
  end

  // Credit: only request when queue plus in-flight words leave room for the response
  always_comb begin
    req_n = (state_n == RUN) && ((32'(count_n) + 32'(out_n)) < 32'(DEPTH));
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      out_q       <= '0;
      drop_q      <= '0;
      count_q     <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      req_q       <= 1'b0;
      valid_IF    <= 1'b0;
      instr_IF    <= '0;
      pc_plus4_IF <= '0;
    end else begin
      pc_q        <= pc_n;
      out_q       <= out_n;
      drop_q      <= drop_n;
      count_q     <= count_n;
      rd_q        <= rd_n;
      wr_q        <= wr_n;
      req_q       <= req_n;
      valid_IF    <= head_valid_n;
      instr_IF    <= head_n.instr;
      pc_plus4_IF <= head_n.pc_plus4;
    end
  end

  // Queue storage
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_entry;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(push && (cnt_pop == CNT_W'(DEPTH))))
        else $error("fetch_stage: queue overflow");
      assert (!(imem.imem_rvalid && (out_q == '0) && (state_q != IDLE)))
        else $error("fetch_stage: response without outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-level reference model compared every cycle,
// plus directed literal expectations for reset, stall, redirect, wrap and mid-cycle reset.
module tb_fetch_stage;

  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch, gnt, late_rv;
  logic [31:0] target;
  logic        valid_m, valid_w;
  logic [31:0] instr_m, pc4_m, instr_w, pc4_w;

  int checks = 0;
  int passed = 0;

  fetch_stage_if if_m ();
  fetch_stage_if if_w ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall_IF(stall), .branch_taken(branch),
    .branch_target(target), .imem(if_m.master),
    .valid_IF(valid_m), .instr_IF(instr_m), .pc_plus4_IF(pc4_m)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .reset(reset), .stall_IF(1'b0), .branch_taken(1'b0),
    .branch_target(32'h0), .imem(if_w.master),
    .valid_IF(valid_w), .instr_IF(instr_w), .pc_plus4_IF(pc4_w)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
  endtask

  // Instruction memories: respond one cycle after each grant
  logic        rv_m, rv_w, rs_gm, rs_gw;
  logic [31:0] rd_m, rd_w, rs_am, rs_aw;
  initial begin rv_m = 0; rv_w = 0; rd_m = 0; rd_w = 0; end

  always @(posedge clk) begin
    rs_gm = if_m.imem_req && if_m.imem_gnt;
    rs_am = if_m.imem_addr;
    rs_gw = if_w.imem_req && if_w.imem_gnt;
    rs_aw = if_w.imem_addr;
    #1;
    rv_m = rs_gm; rd_m = memf(rs_am);
    rv_w = rs_gw; rd_w = memf(rs_aw);
  end

  assign if_m.imem_gnt    = gnt;
  assign if_m.imem_rvalid = rv_m || late_rv;
  assign if_m.imem_rdata  = late_rv ? 32'hDEAD_BEEF : rd_m;
  assign if_w.imem_gnt    = 1'b1;
  assign if_w.imem_rvalid = rv_w;
  assign if_w.imem_rdata  = rd_w;

  // Reference model: held words, in-flight addresses, pending discards, PC
  ent_t        mq[$];
  logic [31:0] mfly[$];
  int          mdrop;
  bit          mstart;
  logic [31:0] mpc;
  bit          m_granted, m_resp;
  logic [31:0] m_ra;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete(); mfly.delete(); mdrop = 0; mstart = 0; mpc = 32'h0;
    end else if (!mstart) begin
      mstart = 1;
    end else begin
      m_granted = (mdrop == 0) && ((mq.size() + mfly.size()) < int'(DEPTH)) && gnt;
      m_resp    = if_m.imem_rvalid && (mfly.size() != 0);
      m_ra      = 32'h0;
      if (m_resp) m_ra = mfly.pop_front();
      if (mdrop != 0) begin
        if (m_resp) mdrop--;
        if (branch) mpc = {target[31:2], 2'b00};
      end else if (branch) begin
        mq.delete();
        if (m_granted) mfly.push_back(mpc);
        mdrop = mfly.size();
        mpc   = {target[31:2], 2'b00};
      end else begin
        if ((mq.size() != 0) && !stall) mq.delete(0);
        if (m_resp) mq.push_back('{instr: if_m.imem_rdata, pc4: m_ra + 32'd4});
        if (m_granted) begin
          mfly.push_back(mpc);
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  // Compare DUT against model every cycle, mid-way between clock edges
  bit   e_req;
  ent_t e_head;
  always @(negedge clk) begin
    e_req  = mstart && (mdrop == 0) && ((mq.size() + mfly.size()) < int'(DEPTH));
    e_head = (mq.size() != 0) ? mq[0] : '0;
    chk("model_req",   {31'b0, if_m.imem_req}, {31'b0, e_req});
    chk("model_addr",  if_m.imem_addr, mpc);
    chk("model_valid", {31'b0, valid_m}, {31'b0, (mq.size() != 0)});
    chk("model_instr", instr_m, e_head.instr);
    chk("model_pc4",   pc4_m, e_head.pc4);
  end

  task automatic wait_valid(input string name);
    for (int n = 0; n < 20 && !valid_m; n++) @(negedge clk);
    chk(name, {31'b0, valid_m}, 32'd1);
  endtask

  task automatic wait_req(input string name);
    for (int n = 0; n < 20 && !if_m.imem_req; n++) @(negedge clk);
    chk(name, {31'b0, if_m.imem_req}, 32'd1);
  endtask

  initial begin
    reset = 1; stall = 0; branch = 0; target = 32'h0; gnt = 1; late_rv = 0;
    repeat (3) @(negedge clk);
    chk("rst_req",   {31'b0, if_m.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, valid_m}, 32'd0);
    chk("rst_instr", instr_m, 32'h0);
    chk("rst_pc4",   pc4_m, 32'h0);
    chk("rst_wrap_addr", if_w.imem_addr, 32'hFFFF_FFF8);
    #2 reset = 0;

    // T1 / T5: fetch stream from reset
    @(negedge clk);
    chk("t1_c1_req",  {31'b0, if_m.imem_req}, 32'd1);
    chk("t1_c1_addr", if_m.imem_addr, 32'h0);
    chk("t5_c1_addr", if_w.imem_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("t1_c2_addr", if_m.imem_addr, 32'h4);
    chk("t5_c2_addr", if_w.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("t1_c3_addr",  if_m.imem_addr, 32'h8);
    chk("t1_c3_valid", {31'b0, valid_m}, 32'd1);
    chk("t1_c3_pc4",   pc4_m, 32'h4);
    chk("t5_c3_addr",  if_w.imem_addr, 32'h0);
    chk("t5_c3_pc4",   pc4_w, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("t1_c4_pc4", pc4_m, 32'h8);
    chk("t5_c4_pc4", pc4_w, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_c6_pc4", pc4_m, 32'hC);

    // T2: stall four cycles with one word shown, second arrives and fills the queue
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_hold_pc4",   pc4_m, 32'hC);
      chk("t2_hold_instr", instr_m, 32'hA5A5_5A52);
      chk("t2_hold_req",   {31'b0, if_m.imem_req}, 32'd0);
    end
    stall = 0;
    @(negedge clk);
    chk("t2_resume_pc4",   pc4_m, 32'h10);
    chk("t2_resume_instr", instr_m, 32'hA5A5_5A56);
    chk("t2_resume_addr",  if_m.imem_addr, 32'h10);

    // T3: redirect with words in flight
    @(negedge clk);
    branch = 1; target = 32'h0000_0040;
    @(negedge clk);
    branch = 0;
    chk("t3_valid_after", {31'b0, valid_m}, 32'd0);
    wait_req("t3_req_wait");
    chk("t3_addr", if_m.imem_addr, 32'h40);
    wait_valid("t3_valid_wait");
    chk("t3_pc4",   pc4_m, 32'h44);
    chk("t3_instr", instr_m, 32'hA5A5_5A1A);

    // T4: redirect while stalled with a full queue; low target bits ignored
    stall = 1;
    repeat (4) @(negedge clk);
    chk("t4_full_req", {31'b0, if_m.imem_req}, 32'd0);
    chk("t4_held_pc4", pc4_m, 32'h44);
    branch = 1; target = 32'h0000_0103;
    @(negedge clk);
    branch = 0; stall = 0;
    chk("t4_valid_after", {31'b0, valid_m}, 32'd0);
    wait_req("t4_req_wait");
    chk("t4_addr", if_m.imem_addr, 32'h100);
    wait_valid("t4_valid_wait");
    chk("t4_pc4", pc4_m, 32'h104);

    // Grant withheld for a few cycles
    gnt = 0;
    repeat (3) @(negedge clk);
    gnt = 1;
    repeat (6) @(negedge clk);

    // Back-to-back redirects (second one may land while discarding) into a wrapping region
    branch = 1; target = 32'hFFFF_FFF0;
    @(negedge clk);
    target = 32'hFFFF_FFF8;
    @(negedge clk);
    branch = 0;
    wait_valid("wrap_valid_wait");
    chk("wrap_pc4",   pc4_m, 32'hFFFF_FFFC);
    chk("wrap_instr", instr_m, 32'h5A5A_A5A2);
    @(negedge clk);
    wait_valid("wrap2_valid_wait");
    chk("wrap2_pc4", pc4_m, 32'h0);

    // T6: asynchronous reset mid-cycle while words are held / in flight
    repeat (2) @(negedge clk);
    stall = 1;
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk("t6_req",   {31'b0, if_m.imem_req}, 32'd0);
    chk("t6_addr",  if_m.imem_addr, 32'h0);
    chk("t6_valid", {31'b0, valid_m}, 32'd0);
    chk("t6_instr", instr_m, 32'h0);
    chk("t6_pc4",   pc4_m, 32'h0);
    stall = 0;
    repeat (2) @(negedge clk);
    #2 reset = 0; late_rv = 1;
    @(posedge clk);
    #1 late_rv = 0;
    @(negedge clk);
    chk("t6_first_req",  {31'b0, if_m.imem_req}, 32'd1);
    chk("t6_first_addr", if_m.imem_addr, 32'h0);
    wait_valid("t6_valid_wait");
    chk("t6_first_pc4",   pc4_m, 32'h4);
    chk("t6_first_instr", instr_m, 32'hA5A5_5A5A);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
